// File: rtl/mem_rd_arbiter.sv
// Round-robin read arbiter: instruction and data cache miss paths share one
// main-memory read port, with one outstanding line read at a time.
module mem_rd_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic              ic_ldp,
   output logic              ic_ldr,
   output logic [LINE_W-1:0] ic_ldData,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic              dc_ldp,
   output logic              dc_ldr,
   output logic [LINE_W-1:0] dc_ldData,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ldp,
   input  logic              mem_ldr,
   input  logic [LINE_W-1:0] mem_ldData
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic GNT_IC = 1'b0;
   localparam logic GNT_DC = 1'b1;

   state_t            state_q;
   logic              win_q;
   logic              last_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_ldp_q;
   logic              ic_ldr_q;
   logic              dc_ldr_q;
   logic [LINE_W-1:0] ic_ldData_q;
   logic [LINE_W-1:0] dc_ldData_q;

   // IC wins when it is the only petitioner or when DC was served last.
   logic grant_ic_c;
   assign grant_ic_c = ic_ldp && (!dc_ldp || (last_q == GNT_DC));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         win_q       <= GNT_IC;
         last_q      <= GNT_DC;
         mem_addr_q  <= '0;
         mem_ldp_q   <= 1'b0;
         ic_ldr_q    <= 1'b0;
         dc_ldr_q    <= 1'b0;
         ic_ldData_q <= '0;
         dc_ldData_q <= '0;
      end else begin
         ic_ldr_q <= 1'b0;
         dc_ldr_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant_ic_c) begin
                  win_q      <= GNT_IC;
                  mem_addr_q <= ic_addr;
                  mem_ldp_q  <= 1'b1;
                  state_q    <= REQ;
               end else if (dc_ldp) begin
                  win_q      <= GNT_DC;
                  mem_addr_q <= dc_addr;
                  mem_ldp_q  <= 1'b1;
                  state_q    <= REQ;
               end
            end
            REQ: begin
               // Line goes straight to the winner so its ldr rises in RESP.
               if (mem_ldr) begin
                  mem_ldp_q <= 1'b0;
                  last_q    <= win_q;
                  state_q   <= RESP;
                  if (win_q == GNT_DC) begin
                     dc_ldr_q    <= 1'b1;
                     dc_ldData_q <= mem_ldData;
                  end else begin
                     ic_ldr_q    <= 1'b1;
                     ic_ldData_q <= mem_ldData;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_ldp   = mem_ldp_q;
   assign ic_ldr    = ic_ldr_q;
   assign dc_ldr    = dc_ldr_q;
   assign ic_ldData = ic_ldData_q;
   assign dc_ldData = dc_ldData_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: inputs driven and outputs checked on the
// falling edge, memory responses driven by hand at fixed cycles.
module tb_mem_rd_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 128;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] ic_addr;
   logic          ic_ldp;
   logic          ic_ldr;
   logic [LW-1:0] ic_ldData;
   logic [AW-1:0] dc_addr;
   logic          dc_ldp;
   logic          dc_ldr;
   logic [LW-1:0] dc_ldData;
   logic [AW-1:0] mem_addr;
   logic          mem_ldp;
   logic          mem_ldr;
   logic [LW-1:0] mem_ldData;

   int n_vec  = 0;
   int n_miss = 0;

   mem_rd_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ic_addr    (ic_addr),
      .ic_ldp     (ic_ldp),
      .ic_ldr     (ic_ldr),
      .ic_ldData  (ic_ldData),
      .dc_addr    (dc_addr),
      .dc_ldp     (dc_ldp),
      .dc_ldr     (dc_ldr),
      .dc_ldData  (dc_ldData),
      .mem_addr   (mem_addr),
      .mem_ldp    (mem_ldp),
      .mem_ldr    (mem_ldr),
      .mem_ldData (mem_ldData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_b(input string tag, input logic got, input logic exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_l(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int got, input int exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_b({tag, "_mem_ldp"}, mem_ldp, 1'b0);
      chk_a({tag, "_mem_addr"}, mem_addr, '0);
      chk_b({tag, "_ic_ldr"}, ic_ldr, 1'b0);
      chk_b({tag, "_dc_ldr"}, dc_ldr, 1'b0);
      chk_l({tag, "_ic_ldData"}, ic_ldData, '0);
      chk_l({tag, "_dc_ldData"}, dc_ldData, '0);
   endtask

   // Leaves the bench at the falling edge of the first post-reset IDLE cycle.
   task automatic do_reset();
      rst_n   = 1'b0;
      ic_ldp  = 1'b0;
      dc_ldp  = 1'b0;
      mem_ldr = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_vals("reset");
   endtask

   logic [LW-1:0] line_a5, line_1, line_2, line_3, line_4, line_5, line_dead, line_f;
   logic          exp_dc;
   int            ic_cnt, dc_cnt;

   initial begin
      line_a5   = {16{8'hA5}};
      line_1    = {4{32'h1111_0001}};
      line_2    = {4{32'h2222_0002}};
      line_3    = {4{32'h3333_0003}};
      line_4    = {4{32'h4444_0004}};
      line_5    = {4{32'h5555_0005}};
      line_dead = {8{16'hDEAD}};
      ic_addr    = '0;
      dc_addr    = '0;
      mem_ldData = '0;
      do_reset();

      // Single IC miss, 3-cycle memory latency.
      ic_addr = 32'h0000_1000;
      ic_ldp  = 1'b1;
      chk_b("ic1_c0_mem_ldp", mem_ldp, 1'b0);
      tick();
      chk_b("ic1_c1_mem_ldp", mem_ldp, 1'b1);
      chk_a("ic1_c1_mem_addr", mem_addr, 32'h0000_1000);
      tick();
      chk_b("ic1_c2_mem_ldp", mem_ldp, 1'b1);
      chk_b("ic1_c2_ic_ldr", ic_ldr, 1'b0);
      tick();
      chk_b("ic1_c3_mem_ldp", mem_ldp, 1'b1);
      chk_a("ic1_c3_mem_addr", mem_addr, 32'h0000_1000);
      mem_ldr    = 1'b1;
      mem_ldData = line_a5;
      tick();
      chk_b("ic1_c4_ic_ldr", ic_ldr, 1'b1);
      chk_l("ic1_c4_ic_ldData", ic_ldData, line_a5);
      chk_b("ic1_c4_dc_ldr", dc_ldr, 1'b0);
      chk_b("ic1_c4_mem_ldp", mem_ldp, 1'b0);
      mem_ldr = 1'b0;
      ic_ldp  = 1'b0;
      tick();
      chk_b("ic1_c5_ic_ldr", ic_ldr, 1'b0);
      chk_b("ic1_c5_mem_ldp", mem_ldp, 1'b0);
      tick();
      chk_b("ic1_c6_no_regrant", mem_ldp, 1'b0);

      // Simultaneous misses after reset: IC first, then DC.
      do_reset();
      ic_addr = 32'h100;
      dc_addr = 32'h200;
      ic_ldp  = 1'b1;
      dc_ldp  = 1'b1;
      tick();
      chk_b("sim_c1_mem_ldp", mem_ldp, 1'b1);
      chk_a("sim_c1_mem_addr", mem_addr, 32'h100);
      mem_ldr    = 1'b1;
      mem_ldData = line_1;
      tick();
      chk_b("sim_c2_ic_ldr", ic_ldr, 1'b1);
      chk_b("sim_c2_dc_ldr", dc_ldr, 1'b0);
      chk_l("sim_c2_ic_ldData", ic_ldData, line_1);
      mem_ldr = 1'b0;
      ic_ldp  = 1'b0;
      tick();
      chk_b("sim_c3_mem_ldp", mem_ldp, 1'b0);
      chk_b("sim_c3_ic_ldr", ic_ldr, 1'b0);
      tick();
      chk_b("sim_c4_mem_ldp", mem_ldp, 1'b1);
      chk_a("sim_c4_mem_addr", mem_addr, 32'h200);
      mem_ldr    = 1'b1;
      mem_ldData = line_2;
      tick();
      chk_b("sim_c5_dc_ldr", dc_ldr, 1'b1);
      chk_b("sim_c5_ic_ldr", ic_ldr, 1'b0);
      chk_l("sim_c5_dc_ldData", dc_ldData, line_2);
      chk_l("sim_c5_ic_ldData_held", ic_ldData, line_1);
      mem_ldr = 1'b0;
      dc_ldp  = 1'b0;
      tick();
      chk_b("sim_c6_dc_ldr", dc_ldr, 1'b0);

      // Fairness: both petition continuously, winner re-asserts right after ldr.
      do_reset();
      ic_addr = 32'h300;
      dc_addr = 32'h400;
      ic_ldp  = 1'b1;
      dc_ldp  = 1'b1;
      ic_cnt  = 0;
      dc_cnt  = 0;
      for (int i = 0; i < 8; i++) begin
         exp_dc = ((i % 2) == 1);
         line_f = {4{32'hC0DE_0000 + 32'(i)}};
         tick();
         chk_b("fair_mem_ldp", mem_ldp, 1'b1);
         chk_a("fair_mem_addr", mem_addr, exp_dc ? 32'h400 : 32'h300);
         mem_ldr    = 1'b1;
         mem_ldData = line_f;
         tick();
         chk_b("fair_ic_ldr", ic_ldr, !exp_dc);
         chk_b("fair_dc_ldr", dc_ldr, exp_dc);
         chk_l("fair_ldData", exp_dc ? dc_ldData : ic_ldData, line_f);
         ic_cnt += int'(ic_ldr);
         dc_cnt += int'(dc_ldr);
         mem_ldr = 1'b0;
         if (i == 7) begin
            ic_ldp = 1'b0;
            dc_ldp = 1'b0;
         end else if (exp_dc) begin
            dc_ldp = 1'b0;
         end else begin
            ic_ldp = 1'b0;
         end
         tick();
         chk_b("fair_idle_ic_ldr", ic_ldr, 1'b0);
         chk_b("fair_idle_dc_ldr", dc_ldr, 1'b0);
         if (i != 7) begin
            ic_ldp = 1'b1;
            dc_ldp = 1'b1;
         end
      end
      chk_i("fair_ic_pulses", ic_cnt, 4);
      chk_i("fair_dc_pulses", dc_cnt, 4);
      tick();
      chk_b("fair_end_mem_ldp", mem_ldp, 1'b0);

      // Late DC petition while an IC read is outstanding.
      do_reset();
      ic_addr = 32'h500;
      ic_ldp  = 1'b1;
      tick();
      chk_b("late_c1_mem_ldp", mem_ldp, 1'b1);
      chk_a("late_c1_mem_addr", mem_addr, 32'h500);
      dc_addr = 32'h600;
      dc_ldp  = 1'b1;
      ic_addr = 32'h777;
      tick();
      chk_a("late_c2_mem_addr_hold", mem_addr, 32'h500);
      chk_b("late_c2_mem_ldp", mem_ldp, 1'b1);
      mem_ldr    = 1'b1;
      mem_ldData = line_3;
      tick();
      chk_b("late_c3_ic_ldr", ic_ldr, 1'b1);
      chk_b("late_c3_dc_ldr", dc_ldr, 1'b0);
      chk_l("late_c3_ic_ldData", ic_ldData, line_3);
      mem_ldr = 1'b0;
      ic_ldp  = 1'b0;
      tick();
      chk_b("late_c4_mem_ldp", mem_ldp, 1'b0);
      tick();
      chk_b("late_c5_mem_ldp", mem_ldp, 1'b1);
      chk_a("late_c5_mem_addr", mem_addr, 32'h600);
      mem_ldr    = 1'b1;
      mem_ldData = line_4;
      tick();
      chk_b("late_c6_dc_ldr", dc_ldr, 1'b1);
      chk_l("late_c6_dc_ldData", dc_ldData, line_4);
      mem_ldr = 1'b0;
      dc_ldp  = 1'b0;
      tick();
      chk_b("late_c7_dc_ldr", dc_ldr, 1'b0);

      // Spurious memory ready while idle.
      mem_ldr    = 1'b1;
      mem_ldData = line_dead;
      tick();
      chk_b("spur_ic_ldr", ic_ldr, 1'b0);
      chk_b("spur_dc_ldr", dc_ldr, 1'b0);
      chk_b("spur_mem_ldp", mem_ldp, 1'b0);
      mem_ldr = 1'b0;
      tick();
      chk_b("spur2_ic_ldr", ic_ldr, 1'b0);
      chk_b("spur2_dc_ldr", dc_ldr, 1'b0);
      chk_l("spur_ic_ldData", ic_ldData, line_3);
      chk_l("spur_dc_ldData", dc_ldData, line_4);

      // Reset while a read is outstanding; the late memory ready is dropped.
      ic_addr = 32'h800;
      ic_ldp  = 1'b1;
      tick();
      chk_b("rst_c1_mem_ldp", mem_ldp, 1'b1);
      rst_n  = 1'b0;
      ic_ldp = 1'b0;
      tick();
      chk_reset_vals("rst_c2");
      rst_n = 1'b1;
      tick();
      mem_ldr    = 1'b1;
      mem_ldData = line_dead;
      tick();
      chk_b("rst_c4_ic_ldr", ic_ldr, 1'b0);
      chk_b("rst_c4_dc_ldr", dc_ldr, 1'b0);
      chk_l("rst_c4_ic_ldData", ic_ldData, '0);
      mem_ldr = 1'b0;
      tick();
      chk_reset_vals("rst_c5");
      ic_addr = 32'h900;
      ic_ldp  = 1'b1;
      tick();
      chk_b("rst_c6_mem_ldp", mem_ldp, 1'b1);
      chk_a("rst_c6_mem_addr", mem_addr, 32'h900);
      mem_ldr    = 1'b1;
      mem_ldData = line_5;
      tick();
      chk_b("rst_c7_ic_ldr", ic_ldr, 1'b1);
      chk_l("rst_c7_ic_ldData", ic_ldData, line_5);
      chk_b("rst_c7_dc_ldr", dc_ldr, 1'b0);
      mem_ldr = 1'b0;
      ic_ldp  = 1'b0;
      tick();
      chk_b("rst_c8_ic_ldr", ic_ldr, 1'b0);
      chk_b("rst_c8_mem_ldp", mem_ldp, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Two-requester read arbiter placed between the instruction cache and the data cache miss paths and the single main-memory read port. Both requesters and the memory use the same petition/ready (ldp/ldr) handshake with a full cache line returned per transaction. The block holds one outstanding memory read at a time, alternates grants round-robin when both caches miss together, and returns each line only to the cache that issued the read.

## Interface
Parameters:
- ADDR_W, default ARCH_LEN: address width.
- LINE_W, default ICLLEN: cache-line data width.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- ic_addr  in  ADDR_W  instruction-cache miss address; stable while ic_ldp is high.
- ic_ldp  in  1  instruction-cache load petition.
- ic_ldr  out  1  one-cycle load-ready pulse to the instruction cache.
- ic_ldData  out  LINE_W  returned line; valid when ic_ldr is high.
- dc_addr  in  ADDR_W  data-cache miss address; stable while dc_ldp is high.
- dc_ldp  in  1  data-cache load petition.
- dc_ldr  out  1  one-cycle load-ready pulse to the data cache.
- dc_ldData  out  LINE_W  returned line; valid when dc_ldr is high.
- mem_addr  out  ADDR_W  memory read address.
- mem_ldp  out  1  memory load petition.
- mem_ldr  in  1  memory load ready.
- mem_ldData  in  LINE_W  memory line; valid when mem_ldr is high.

## Operation
- States: IDLE, REQ, RESP. All outputs are registered.
- IDLE:
  - Sample ic_ldp and dc_ldp.
  - If only one is high, grant it.
  - If both are high, grant the port that was not granted last; the last-grant flag resets to DC, so IC wins the first tie.
  - On a grant: latch the winner id and its address into mem_addr, set mem_ldp, and move to REQ.
  - If neither is high, stay in IDLE.
- REQ:
  - mem_ldp stays high and mem_addr holds.
  - Requester petitions and address changes are ignored; the latched address is used.
  - On mem_ldr: capture mem_ldData, clear mem_ldp, update the last-grant flag to the winner, and move to RESP.
  - There is no timeout; the block waits indefinitely.
- RESP:
  - Drive the winner's ldr high for exactly one cycle, with the captured line on its ldData.
  - The other port's ldr stays 0.
  - Return to IDLE.
- Requester obligation: deassert ldp on the clock edge after it sees ldr. The IDLE cycle that follows RESP then samples the petition low, so the same request is never re-granted.
- A loser keeps ldp high. It is granted in the next IDLE cycle after the current transaction ends.
- mem_ldr while in IDLE or RESP is ignored and captures nothing.
- ldData outputs:
  - Each port's ldData holds its last delivered line; it is not cleared between transactions.
  - It updates only in the cycle its ldr rises.
- Reset (rst_n low at a clock edge, in any state):
  - State goes to IDLE and last-grant goes to DC.
  - mem_ldp=0, mem_addr=0, ic_ldr=0, dc_ldr=0, ic_ldData=0, dc_ldData=0.
  - An in-flight memory read is abandoned. A later mem_ldr for it is ignored, because the block is in IDLE.

## Timing
- Cycle 0: petition sampled high in IDLE.
- Cycle 1: mem_ldp high with mem_addr valid.
- mem_ldr high in cycle k (k≥1) → requester ldr high in cycle k+1.
- Minimum request-to-ldr latency is 2 cycles, when memory answers in the same cycle mem_ldp rises.
- Back-to-back transactions: RESP at cycle t, IDLE at t+1, the next mem_ldp at t+2. Throughput is therefore at most one line per (memory latency + 3) cycles.
- mem_ldp falls in the cycle after mem_ldr, so memory sees mem_ldp high in the mem_ldr cycle. Memory must return exactly one mem_ldr pulse per petition.
- Both ldr outputs are never high in the same cycle.

## Test plan
- Single IC miss:
  - Stimulus: ic_addr=0x0000_1000, ic_ldp high at cycle 0; memory returns line 0xA5… with fixed 3-cycle latency.
  - Required: mem_ldp high cycles 1–3 with mem_addr=0x1000; ic_ldr high only at cycle 4 with ic_ldData=0xA5…; dc_ldr stays 0.
- Simultaneous misses after reset:
  - Stimulus: ic_ldp and dc_ldp both high at cycle 0 (ic_addr=0x100, dc_addr=0x200).
  - Required: first mem_addr=0x100 and IC receives its line; the second grant goes to DC with mem_addr=0x200; each ldr pulses once.
- Fairness:
  - Stimulus: both ports petition continuously, re-asserting immediately after each ldr, for 8 transactions.
  - Required: grant order IC, DC, IC, DC…; each port gets exactly 4 ldr pulses.
- Late petition during REQ:
  - Stimulus: DC petitions while an IC read is in REQ.
  - Required: mem_addr does not change mid-transaction; DC is granted in the IDLE cycle right after IC's RESP.
- Spurious memory ready:
  - Stimulus: mem_ldr pulsed with data 0xDEAD… while in IDLE.
  - Required: no ldr pulse on either port; both ldData values unchanged.
- Reset mid-REQ:
  - Stimulus: rst_n low for one cycle while mem_ldp is high; memory then returns mem_ldr two cycles later with no petition pending.
  - Required: mem_ldp=0 the cycle after reset is sampled; all outputs at reset values; no ldr pulse; the next IC request completes normally.
